idma_rd_burst_gen: RTL and testbench
====================================

# idma_rd_burst_gen

Read-side AXI address generator of the iDMA. Accepts one transfer command (source byte address, byte length), splits it into AXI INCR read bursts on the AR channel and limits the number of outstanding bursts. It supplies the downstream read-data processing stage with the per-transfer strobe offsets and the per-burst first/last flags, and retires each burst on that stage's `axi_burst_rdata_ok` pulse.

## Interface
- `AXI_IDW`, 4, AR ID width
- `AXI_ADDR_WID`, 32, address width
- `AXI_DATA_WID`, 256, data width; beat = 32 bytes, fixed
- `LEN_WID`, 20, command byte-length width
- `MAX_BURST_LEN`, 16, maximum beats per burst (1..256)
- `MAX_OUTSTANDING`, 4, maximum AR bursts in flight without data (power of 2)

Ports:
- `aclk` in 1: clock
- `aresetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake
- `cmd_src_addr` in AXI_ADDR_WID: first byte address
- `cmd_byte_len` in LEN_WID: byte count
- `cmd_id` in AXI_IDW: driven on `o_arid`
- `o_arvalid` out 1, `i_arready` in 1: AR handshake
- `o_araddr` out AXI_ADDR_WID, `o_arlen` out 8, `o_arsize` out 3, `o_arburst` out 2, `o_arid` out AXI_IDW
- `axi_burst_rdata_ok` in 1: rlast beat accepted downstream
- `strb_first_beat_num` out 6, `strb_last_beat_num` out 6
- `dma_trans_first_burst` out 1, `dma_trans_last_burst` out 1
- `busy` out 1, `done` out 1: one-cycle completion pulse

## Operation
- FSM states: IDLE, CALC, ISSUE, DRAIN. `cmd_ready` = 1 only in IDLE.
- IDLE → CALC on command handshake. In CALC, latch the command and compute:
  - `beats_left` = (addr[4:0] + len + 31) >> 5
  - `strb_first_beat_num` = {1'b0, addr[4:0]}
  - `strb_last_beat_num` = {1'b0, (addr+len)[4:0]}; 0 means a full last beat
  - `cur_addr` = addr & ~31
  - `len` = 0: skip ISSUE; go to IDLE and pulse `done` the next cycle.
- ISSUE: burst beats = min(MAX_BURST_LEN, `beats_left`, 4 KB limit (see Configuration)).
  - `o_arlen` = beats−1, `o_arsize` = 3'b101, `o_arburst` = 2'b01 (INCR).
  - On handshake: `cur_addr` += beats×32, `beats_left` −= beats, push flags {is_first, is_last} into the flag FIFO.
  - When `beats_left` reaches 0, go to DRAIN.
- DRAIN: when outstanding reaches 0, go to IDLE with a `done` pulse.
- Outstanding counter:
  - +1 on AR handshake, −1 on `axi_burst_rdata_ok`; unchanged when both occur in the same cycle.
  - Do not assert `o_arvalid` while the counter = MAX_OUTSTANDING.
- `dma_trans_first_burst` / `dma_trans_last_burst` = head entry of the flag FIFO; 0 when the FIFO is empty.
  - Pop on `axi_burst_rdata_ok`.
  - A single-burst transfer drives both flags to 1.
- `axi_burst_rdata_ok` with an empty FIFO is ignored: no pop, the counter does not underflow.
- `busy` = state ≠ IDLE.

## Timing
- All outputs reset to 0, including `cmd_ready`. `cmd_ready` goes to 1 on the first cycle after reset release.
- `o_arvalid` rises the cycle after CALC.
- AR payload is held stable while `o_arvalid & !i_arready`.
- After an AR handshake, the next burst is presented in the following cycle (one AR per cycle maximum).
- Strobe outputs are registered in CALC and held until the next command's CALC.
- `done` pulses the cycle after the final `axi_burst_rdata_ok`.
- Reset mid-transfer: FSM, counters and the flag FIFO are cleared immediately. In-flight R data is not tracked.

## Configuration
- `IDMA_RD_4K_SPLIT_EN` defined: burst beats are also limited to (4096 − cur_addr[11:0]) >> 5, so no burst crosses a 4 KB boundary.
- Undefined: only the MAX_BURST_LEN and `beats_left` limits apply.

## Structure
- Shared package `idma_pkg`: `AXI_BURST_INCR`, `AXI_SIZE_32B`, `BEAT_BYTES`, `BOUNDARY_4K`, FSM state enum.
- Sub-module `idma_burst_flag_fifo`:
  - 2-bit wide, MAX_OUTSTANDING deep.
  - Registered head; full/empty derived from pointers with a wrap bit.

## Test plan
- addr 0x1000, len 64 → one AR: araddr 0x1000, arlen 1. strb_first 0, strb_last 0. Both flags 1 until rlast; `done` on the next cycle.
- addr 0x1005, len 100 → araddr 0x1000, arlen 3, strb_first 5, strb_last 9.
- addr 0x0FC0, len 256, macro on → AR 0x0FC0/arlen 1, then 0x1000/arlen 5. First flag set only on burst 1, last flag only on burst 2. Macro off → single AR with arlen 7.
- addr 0x2000, len 1024, MAX_OUTSTANDING=1, `i_arready` low 5 cycles → araddr 0x2000 held stable. Second AR (0x2200, arlen 15) appears only after the first `axi_burst_rdata_ok`.
- len 0 → no `o_arvalid`; `done` pulses 2 cycles after the command handshake.
- `aresetn` low during DRAIN → all outputs 0. A new command is then accepted and completes normally.

Source files
------------

// File: rtl/idma_pkg.sv
// Shared iDMA constants and the read burst generator FSM encoding.
package idma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam int         BEAT_BYTES     = 32;
    localparam int         BOUNDARY_4K    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/idma_burst_flag_fifo.sv
// Small FIFO of per-burst {first, last} flags with a registered head entry.
module idma_burst_flag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    mem_q [2**AW];
    logic [AW:0]   wr_ptr_q, rd_ptr_q, count;
    logic [AW-1:0] wr_idx, rd_nxt_idx;
    logic [1:0]    head_q;
    logic          full, do_push, do_pop;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (count == (AW+1)'(DEPTH));
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign head       = head_q;

    // NOTE: storage is not reset; the pointers alone say which entries are valid.
    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_idx] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            // Head reads zero whenever the FIFO is empty.
            if (do_pop) begin
                if (count > (AW+1)'(1)) head_q <= mem_q[rd_nxt_idx];
                else if (do_push)       head_q <= push_data;
                else                    head_q <= '0;
            end else if (empty && do_push) begin
                head_q <= push_data;
            end
        end
    end

endmodule

// File: rtl/idma_rd_burst_gen.sv
// iDMA read-side AR burst generator: splits one transfer into INCR bursts and bounds bursts in flight.
// Optional macro IDMA_RD_4K_SPLIT_EN additionally stops every burst at a 4 KB boundary.
module idma_rd_burst_gen
    import idma_pkg::*;
#(
    parameter int AXI_IDW         = 4,
    parameter int AXI_ADDR_WID    = 32,
    parameter int AXI_DATA_WID    = 256,
    parameter int LEN_WID         = 20,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXI_ADDR_WID-1:0] cmd_src_addr,
    input  logic [LEN_WID-1:0]      cmd_byte_len,
    input  logic [AXI_IDW-1:0]      cmd_id,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [AXI_ADDR_WID-1:0] o_araddr,
    output logic [7:0]              o_arlen,
    output logic [2:0]              o_arsize,
    output logic [1:0]              o_arburst,
    output logic [AXI_IDW-1:0]      o_arid,
    input  logic                    axi_burst_rdata_ok,
    output logic [5:0]              strb_first_beat_num,
    output logic [5:0]              strb_last_beat_num,
    output logic                    dma_trans_first_burst,
    output logic                    dma_trans_last_burst,
    output logic                    busy,
    output logic                    done
);

    localparam int OFF_W  = $clog2(AXI_DATA_WID / 8);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BL_W   = LEN_WID - OFF_W + 2;
    localparam int BEAT_W = 9;

    rd_state_e               state_q, state_d;
    logic [AXI_ADDR_WID-1:0] cmd_addr_q, cur_addr_q;
    logic [LEN_WID-1:0]      cmd_len_q;
    logic [AXI_IDW-1:0]      arid_q;
    logic [BL_W-1:0]         beats_left_q, beats_calc;
    logic [LEN_WID:0]        span;
    logic [OFF_W-1:0]        end_off;
    logic [5:0]              strb_first_q, strb_last_q;
    logic [OUT_W-1:0]        outstanding_q, outstanding_d;
    logic [BEAT_W-1:0]       burst_beats;
    logic                    first_q, ready_q, done_q;
    logic                    cmd_hs, ar_hs, pop_ok, is_last, issuing, fifo_empty;

    assign span       = {1'b0, cmd_len_q} + (LEN_WID+1)'(cmd_addr_q[OFF_W-1:0])
                      + (LEN_WID+1)'(BEAT_BYTES - 1);
    assign beats_calc = BL_W'(span >> OFF_W);
    assign end_off    = cmd_addr_q[OFF_W-1:0] + cmd_len_q[OFF_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        burst_beats = BEAT_W'(MAX_BURST_LEN);
        if (beats_left_q < BL_W'(MAX_BURST_LEN)) burst_beats = BEAT_W'(beats_left_q);
`ifdef IDMA_RD_4K_SPLIT_EN
        begin : room_limit
            logic [12:0] room_4k;
            room_4k = 13'(BOUNDARY_4K) - {1'b0, cur_addr_q[11:0]};
            if (BEAT_W'(room_4k >> OFF_W) < burst_beats) burst_beats = BEAT_W'(room_4k >> OFF_W);
        end
`endif
    end

    assign issuing   = (state_q == ST_ISSUE);
    assign o_arvalid = issuing && (outstanding_q != OUT_W'(MAX_OUTSTANDING));
    assign ar_hs     = o_arvalid & i_arready;
    assign cmd_hs    = cmd_valid & ready_q;
    assign pop_ok    = axi_burst_rdata_ok & ~fifo_empty;
    assign is_last   = (beats_left_q == BL_W'(burst_beats));
    assign outstanding_d = outstanding_q + OUT_W'(ar_hs) - OUT_W'(pop_ok);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_hs) state_d = ST_CALC;
            ST_CALC:  state_d = (cmd_len_q == '0) ? ST_IDLE : ST_ISSUE;
            ST_ISSUE: if (ar_hs && is_last) state_d = ST_DRAIN;
            ST_DRAIN: if (outstanding_d == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            outstanding_q <= '0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            arid_q        <= '0;
            cur_addr_q    <= '0;
            beats_left_q  <= '0;
            strb_first_q  <= '0;
            strb_last_q   <= '0;
            first_q       <= 1'b0;
        end else begin
            ready_q       <= (state_d == ST_IDLE);
            done_q        <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
            outstanding_q <= outstanding_d;
            if (state_q == ST_IDLE && cmd_hs) begin
                cmd_addr_q <= cmd_src_addr;
                cmd_len_q  <= cmd_byte_len;
                arid_q     <= cmd_id;
            end
            if (state_q == ST_CALC) begin
                beats_left_q <= beats_calc;
                strb_first_q <= 6'(cmd_addr_q[OFF_W-1:0]);
                strb_last_q  <= 6'(end_off);
                cur_addr_q   <= {cmd_addr_q[AXI_ADDR_WID-1:OFF_W], {OFF_W{1'b0}}};
                first_q      <= 1'b1;
            end else if (ar_hs) begin
                cur_addr_q   <= cur_addr_q + (AXI_ADDR_WID'(burst_beats) << OFF_W);
                beats_left_q <= beats_left_q - BL_W'(burst_beats);
                first_q      <= 1'b0;
            end
        end
    end

    idma_burst_flag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_flag_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (ar_hs),
        .push_data ({first_q, is_last}),
        .pop       (axi_burst_rdata_ok),
        .head      ({dma_trans_first_burst, dma_trans_last_burst}),
        .empty     (fifo_empty)
    );

    // AR payload reads zero outside ISSUE so nothing stale leaks out after reset or between commands.
    assign o_araddr  = issuing ? cur_addr_q : '0;
    assign o_arlen   = issuing ? 8'(burst_beats - BEAT_W'(1)) : 8'd0;
    assign o_arsize  = issuing ? AXI_SIZE_32B : 3'b000;
    assign o_arburst = issuing ? AXI_BURST_INCR : 2'b00;
    assign o_arid    = issuing ? arid_q : '0;

    assign cmd_ready           = ready_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = done_q;
    assign strb_first_beat_num = strb_first_q;
    assign strb_last_beat_num  = strb_last_q;

endmodule

// File: tb/tb_idma_rd_burst_gen.sv
// Randomized self-checking bench for idma_rd_burst_gen against a burst-list reference model.
// Honours IDMA_RD_4K_SPLIT_EN the same way the design does.
module tb_idma_rd_burst_gen;

    localparam int MAX_BL  = 16;
    localparam int MAX_OUT = 4;

    logic        aclk, aresetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_src_addr;
    logic [19:0] cmd_byte_len;
    logic [3:0]  cmd_id;
    logic        o_arvalid, i_arready;
    logic [31:0] o_araddr;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic [3:0]  o_arid;
    logic        axi_burst_rdata_ok;
    logic [5:0]  strb_first_beat_num, strb_last_beat_num;
    logic        dma_trans_first_burst, dma_trans_last_burst;
    logic        busy, done;

    idma_rd_burst_gen #(
        .AXI_IDW         (4),
        .AXI_ADDR_WID    (32),
        .AXI_DATA_WID    (256),
        .LEN_WID         (20),
        .MAX_BURST_LEN   (MAX_BL),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_src_addr          (cmd_src_addr),
        .cmd_byte_len          (cmd_byte_len),
        .cmd_id                (cmd_id),
        .o_arvalid             (o_arvalid),
        .i_arready             (i_arready),
        .o_araddr              (o_araddr),
        .o_arlen               (o_arlen),
        .o_arsize              (o_arsize),
        .o_arburst             (o_arburst),
        .o_arid                (o_arid),
        .axi_burst_rdata_ok    (axi_burst_rdata_ok),
        .strb_first_beat_num   (strb_first_beat_num),
        .strb_last_beat_num    (strb_last_beat_num),
        .dma_trans_first_burst (dma_trans_first_burst),
        .dma_trans_last_burst  (dma_trans_last_burst),
        .busy                  (busy),
        .done                  (done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        int          beats;
        bit          first;
        bit          last;
    } burst_t;

    burst_t exp_q[$];   // bursts the model expects on AR, in order
    burst_t acc_q[$];   // bursts accepted on AR and not yet retired
    int     n_checks, n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: walk the aligned beat range and cut it into bursts by plain arithmetic.
    function automatic void build_model(input logic [31:0] addr, input int len);
        logic [31:0] ptr;
        int          rem, n;
        bit          first;
        exp_q.delete();
        ptr   = addr & ~32'd31;
        rem   = (int'(addr % 32) + len + 31) / 32;
        first = 1'b1;
        while (rem > 0) begin
            n = (rem < MAX_BL) ? rem : MAX_BL;
`ifdef IDMA_RD_4K_SPLIT_EN
            if ((4096 - int'(ptr % 4096)) / 32 < n) n = (4096 - int'(ptr % 4096)) / 32;
`endif
            exp_q.push_back('{addr: ptr, beats: n, first: first, last: (n == rem)});
            ptr   = ptr + 32'(n * 32);
            rem   = rem - n;
            first = 1'b0;
        end
    endfunction

    task automatic run_cmd(input logic [31:0] addr, input int len, input int rdy_pct,
                           input int ok_pct, input int stall, input bit drain_only);
        logic [3:0]  id;
        logic [31:0] stall_addr;
        logic [7:0]  stall_len;
        burst_t      b;
        int          t;
        bit          done_due, done_next, stalled, finished, ok, hs;
        id = 4'($urandom);
        build_model(addr, len);
        acc_q.delete();
        t = 0;
        @(negedge aclk);
        while (!cmd_ready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check("cmd_ready", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_src_addr = addr;
        cmd_byte_len = 20'(len);
        cmd_id       = id;
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("busy", busy, 1);
        done_due   = 1'b0;
        done_next  = (len == 0);
        stalled    = 1'b0;
        finished   = 1'b0;
        stall_addr = '0;
        stall_len  = '0;
        for (int k = 0; k < 4000; k++) begin
            if (k == 1) begin
                check("strb_first", strb_first_beat_num, 6'(addr % 32));
                check("strb_last", strb_last_beat_num, 6'((addr + 32'(len)) % 32));
                if (len != 0) check("arvalid_rise", o_arvalid, 1);
            end
            check("done", done, done_due);
            if (done_due) begin
                finished = 1'b1;
                break;
            end
            if (acc_q.size() == MAX_OUT) check("arvalid_at_limit", o_arvalid, 0);
            if (stalled) begin
                check("ar_hold_valid", o_arvalid, 1);
                check("ar_hold_addr", o_araddr, stall_addr);
                check("ar_hold_len", o_arlen, stall_len);
            end
            i_arready = (k >= stall) && ($urandom_range(99) < rdy_pct);
            ok = 1'b0;
            if (!drain_only) ok = $urandom_range(99) < ((acc_q.size() > 0) ? ok_pct : 10);
            axi_burst_rdata_ok = ok;
            if (acc_q.size() == 0) begin
                check("flags_empty", {dma_trans_first_burst, dma_trans_last_burst}, 2'b00);
            end else if (ok) begin
                b = acc_q.pop_front();
                check("flag_first", dma_trans_first_burst, b.first);
                check("flag_last", dma_trans_last_burst, b.last);
                if (acc_q.size() == 0 && exp_q.size() == 0) done_next = 1'b1;
            end
            #1;
            hs = o_arvalid && i_arready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ar", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("araddr", o_araddr, b.addr);
                    check("arlen", o_arlen, 8'(b.beats - 1));
                    check("arsize", o_arsize, 3'b101);
                    check("arburst", o_arburst, 2'b01);
                    check("arid", o_arid, id);
                    acc_q.push_back(b);
                end
            end
            stalled    = o_arvalid && !i_arready;
            stall_addr = o_araddr;
            stall_len  = o_arlen;
            done_due   = done_next;
            done_next  = 1'b0;
            if (drain_only && hs && exp_q.size() == 0) begin
                i_arready = 1'b0;
                @(negedge aclk);
                finished = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        i_arready          = 1'b0;
        axi_burst_rdata_ok = 1'b0;
        if (!finished) check("timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ar"}, {o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid}, 0);
        check({tag, "_ctl"}, {cmd_ready, strb_first_beat_num, strb_last_beat_num,
                              dma_trans_first_burst, dma_trans_last_burst, busy, done}, 0);
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        aresetn            = 1'b0;
        cmd_valid          = 1'b0;
        cmd_src_addr       = '0;
        cmd_byte_len       = '0;
        cmd_id             = '0;
        i_arready          = 1'b0;
        axi_burst_rdata_ok = 1'b0;
        repeat (3) @(negedge aclk);
        check_all_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check("ready_after_reset", cmd_ready, 1);
        check("idle_busy", busy, 0);

        run_cmd(32'h0000_1000,   64, 100, 50, 0, 1'b0);
        run_cmd(32'h0000_1005,  100, 100, 50, 0, 1'b0);
        run_cmd(32'h0000_0FC0,  256, 100, 50, 0, 1'b0);
        run_cmd(32'h0000_2000, 1024, 100, 50, 5, 1'b0);
        run_cmd(32'h0000_3004,    0, 100, 50, 0, 1'b0);
        run_cmd(32'h0000_4000, 8192, 100,  3, 0, 1'b0);

        // Reset while bursts are still outstanding, then a normal transfer.
        run_cmd(32'h0000_1000, 64, 100, 0, 0, 1'b1);
        check("busy_in_drain", busy, 1);
        aresetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        acc_q.delete();
        @(negedge aclk);
        check("ready_after_mid_reset", cmd_ready, 1);
        run_cmd(32'h0000_1000, 64, 100, 50, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom & 32'h0FFF_FFFF,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4000),
                    $urandom_range(30, 100), $urandom_range(25, 90), $urandom_range(0, 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
